// File: rtl/instr_feeder_pkg.sv
// Shared types and default sizes for the instruction feeder.
package instr_feeder_pkg;

  localparam int PC_W_DEF    = 3;
  localparam int INSTR_W_DEF = 32;
  localparam int DEPTH_DEF   = 8;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/instr_feeder_mem.sv
// Instruction buffer: synchronous write, registered read, new data wins on an address collision.
module instr_feeder_mem
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PC_W-1:0]    wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [PC_W-1:0]    rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] slots [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) slots[wr_addr] <= wr_data;
    if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                               rd_data <= slots[rd_addr];
  end

endmodule

// File: rtl/instr_feeder.sv
// Issues buffered instructions start_pc..max_pc over a valid/ack handshake.
// Define INSTR_FEEDER_SKIP_NOP_EN to skip all-zero slots instead of issuing them.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic [PC_W-1:0]    max_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ack,
  output logic               busy,
  output logic               done,
  output logic [PC_W:0]      issued_count
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    last;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               wr_en;
  logic               nop_slot;

  assign wr_en   = load_en && (state == IDLE);
  assign pc_next = pc + PC_W'(1);
  assign busy    = (state != IDLE);

`ifdef INSTR_FEEDER_SKIP_NOP_EN
  assign nop_slot = (rd_data == INSTR_W'(NOP_WORD));
`else
  assign nop_slot = 1'b0;
`endif

  // The read is registered, so the address of the slot FETCH will need is
  // presented one cycle ahead, from whatever transition leads into FETCH.
  always_comb begin
    rd_addr = pc;
    case (state)
      IDLE:    if (start) rd_addr = start_pc;
      FETCH:   if (nop_slot && (pc != last)) rd_addr = pc_next;
      ISSUE:   if (instr_ack && (pc != last)) rd_addr = pc_next;
      default: rd_addr = pc;
    endcase
  end

  instr_feeder_mem #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(load_addr),
    .wr_data(load_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      last         <= '0;
      instr        <= '0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc           <= start_pc;
            last         <= max_pc;
            issued_count <= '0;
            if (start_pc > max_pc) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (nop_slot) begin
            if (pc == last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              pc <= pc_next;
            end
          end else begin
            instr       <= rd_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ack) begin
            instr_valid  <= 1'b0;
            issued_count <= issued_count + (PC_W+1)'(1);
            if (pc == last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              pc    <= pc_next;
              state <= FETCH;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder; the reference model lists the expected issue stream per run.
`timescale 1ns/1ps
module tb_instr_feeder;
  localparam int PC_W    = 3;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load_en = 1'b0;
  logic [PC_W-1:0]    load_addr = '0;
  logic [INSTR_W-1:0] load_data = '0;
  logic               start = 1'b0;
  logic [PC_W-1:0]    start_pc = '0;
  logic [PC_W-1:0]    max_pc = '0;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ack = 1'b0;
  logic               busy;
  logic               done;
  logic [PC_W:0]      issued_count;

  int checks = 0;
  int errors = 0;

  logic [INSTR_W-1:0] model_mem [DEPTH];
  logic [INSTR_W-1:0] exp_w[$];
  logic [INSTR_W-1:0] got_w[$];
  int                 exp_pc[$];
  int                 got_pc[$];
  int first_lat, done_cyc, last_ack_cyc, done_pulses, stab_err, idle_cyc, stall_count;
  bit timeout;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  instr_feeder dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .start_pc(start_pc), .max_pc(max_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .busy(busy), .done(done),
    .issued_count(issued_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [INSTR_W-1:0] d);
    load_en = 1'b1; load_addr = PC_W'(a); load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Expected stream: every slot in [s, m] in PC order, zero words dropped when skipping is on.
  function automatic void build_expected(input int s, input int m);
    exp_w.delete(); exp_pc.delete();
    for (int p = s; p <= m; p++) begin
`ifdef INSTR_FEEDER_SKIP_NOP_EN
      if (model_mem[p] == 0) continue;
`endif
      exp_w.push_back(model_mem[p]);
      exp_pc.push_back(p);
    end
  endfunction

  // Starts one run and observes it until busy drops; cycle k is the k-th cycle after the start edge.
  task automatic drive_run(input int s, input int m, input int ack_pct, input int stall_pc,
                           input int stall_len, input int inject_cyc, input bit same_ld,
                           input int ld_addr, input logic [INSTR_W-1:0] ld_data);
    int cyc = 0;
    int stalled = 0;
    bit ack;
    bit prev_hold = 1'b0;
    logic [INSTR_W-1:0] prev_w = '0;
    logic [PC_W-1:0] prev_pc = '0;
    got_w.delete(); got_pc.delete();
    first_lat = -1; done_cyc = -1; last_ack_cyc = -1; done_pulses = 0;
    stab_err = 0; idle_cyc = -1; timeout = 1'b0;
    if (same_ld) begin
      load_en = 1'b1; load_addr = PC_W'(ld_addr); load_data = ld_data;
      model_mem[ld_addr] = ld_data;
    end
    build_expected(s, m);
    start = 1'b1; start_pc = PC_W'(s); max_pc = PC_W'(m);
    tick();
    cyc = 1;
    forever begin
      start = 1'b0; load_en = 1'b0;
      if (!busy) begin idle_cyc = cyc; break; end
      if (done) begin done_pulses++; if (done_cyc < 0) done_cyc = cyc; end
      if (instr_valid && first_lat < 0) first_lat = cyc;
      if (prev_hold && (!instr_valid || instr !== prev_w || instr_pc !== prev_pc)) stab_err++;
      if (cyc == inject_cyc) begin
        start = 1'b1; start_pc = 3'd7; max_pc = 3'd7;
        load_en = 1'b1; load_addr = 3'd0; load_data = 32'hDEADBEEF;
      end
      ack = (int'($urandom_range(99)) < ack_pct);
      if (instr_valid && int'(instr_pc) == stall_pc && stalled < stall_len) begin
        ack = 1'b0;
        stalled++;
        if (instr !== model_mem[stall_pc]) stab_err++;
      end
      instr_ack = ack;
      if (ack && instr_valid) begin
        got_w.push_back(instr); got_pc.push_back(int'(instr_pc)); last_ack_cyc = cyc;
      end
      prev_hold = instr_valid && !ack; prev_w = instr; prev_pc = instr_pc;
      tick();
      cyc++;
      if (cyc > 300) begin timeout = 1'b1; break; end
    end
    instr_ack = 1'b0; start = 1'b0; load_en = 1'b0;
    stall_count = stalled;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({instr, instr_pc, instr_valid, busy, done, issued_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: instr=%h pc=%0d valid=%b busy=%b done=%b count=%0d, required all 0",
               instr, instr_pc, instr_valid, busy, done, issued_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_run();
    load(0, 32'h1401002D); load(1, 32'h1402FFEC); load(2, 32'h1403FFC4);
    load(3, 32'h00222821); load(4, 32'h00643021); load(5, 32'h00A62823);
    drive_run(0, 5, 100, -1, 0, -1, 1'b0, 0, '0);
    checks++;
    if (timeout || got_w.size() != 6) begin
      errors++; $display("FAIL basic_issues: got %0d (timeout=%0b), required 6", got_w.size(), timeout);
    end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_pc[i] !== exp_pc[i]) begin
        errors++; $display("FAIL basic_word%0d: got pc %0d %h, required pc %0d %h",
                           i, got_pc[i], got_w[i], exp_pc[i], exp_w[i]);
      end
    end
    checks++;
    if (first_lat != 2) begin errors++; $display("FAIL basic_first_valid: got cycle %0d, required 2", first_lat); end
    checks++;
    if (done_cyc != last_ack_cyc + 1 || done_pulses != 1) begin
      errors++; $display("FAIL basic_done: done at %0d (%0d pulses), required %0d (1 pulse)",
                         done_cyc, done_pulses, last_ack_cyc + 1);
    end
    checks++;
    if (idle_cyc != done_cyc + 1) begin errors++; $display("FAIL basic_idle: got %0d, required %0d", idle_cyc, done_cyc + 1); end
    checks++;
    if (issued_count !== 4'd6) begin errors++; $display("FAIL basic_count: got %0d, required 6", issued_count); end
  endtask

  task automatic test_stall();
    drive_run(0, 5, 100, 2, 7, -1, 1'b0, 0, '0);
    checks++;
    if (stall_count != 7 || stab_err != 0) begin
      errors++; $display("FAIL stall_hold: stalled %0d cycles with %0d unstable, required 7 and 0", stall_count, stab_err);
    end
    checks++;
    if (timeout || got_w.size() != 6 || issued_count !== 4'd6) begin
      errors++; $display("FAIL stall_issues: got %0d issues count %0d, required 6", got_w.size(), issued_count);
    end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_pc[i] !== exp_pc[i]) begin
        errors++; $display("FAIL stall_word%0d: got pc %0d %h, required pc %0d %h",
                           i, got_pc[i], got_w[i], exp_pc[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_empty_range();
    drive_run(4, 2, 100, -1, 0, -1, 1'b0, 0, '0);
    checks++;
    if (done_cyc != 1 || done_pulses != 1 || idle_cyc != 2) begin
      errors++; $display("FAIL empty_done: done at %0d (%0d pulses) idle at %0d, required 1 (1) and 2",
                         done_cyc, done_pulses, idle_cyc);
    end
    checks++;
    if (first_lat != -1 || got_w.size() != 0 || issued_count !== 4'd0) begin
      errors++; $display("FAIL empty_issue: first valid %0d issues %0d count %0d, required none and 0",
                         first_lat, got_w.size(), issued_count);
    end
  endtask

  task automatic test_midrun_reset();
    int n = 0;
    bit seen = 1'b0;
    start = 1'b1; start_pc = 3'd0; max_pc = 3'd5;
    tick();
    start = 1'b0;
    while (n < 100 && !(instr_valid && instr_pc == 3'd3)) begin
      instr_ack = instr_valid;
      tick();
      n++;
    end
    instr_ack = 1'b0;
    checks++;
    if (n >= 100) begin errors++; $display("FAIL midrst_reach: PC 3 not issued within 100 cycles, required reached"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({instr, instr_pc, instr_valid, busy, done, issued_count} !== '0) begin
      errors++; $display("FAIL midrst_outputs: instr=%h pc=%0d valid=%b busy=%b done=%b count=%0d, required all 0",
                         instr, instr_pc, instr_valid, busy, done, issued_count);
    end
    for (int i = 0; i < 4; i++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_quiet: got done/busy after reset, required none"); end
    drive_run(0, 5, 100, -1, 0, -1, 1'b0, 0, '0);
    checks++;
    if (got_w.size() != 6 || got_w[0] !== 32'h1401002D) begin
      errors++; $display("FAIL midrst_restart: got %0d issues first %h, required 6 first 1401002d",
                         got_w.size(), (got_w.size() > 0) ? got_w[0] : 32'h0);
    end
  endtask

  task automatic test_ignore_busy();
    drive_run(0, 5, 100, -1, 0, 3, 1'b0, 0, '0);
    checks++;
    if (timeout || got_w.size() != exp_w.size() || done_pulses != 1) begin
      errors++; $display("FAIL busy_run: got %0d issues %0d done pulses, required %0d and 1",
                         got_w.size(), done_pulses, exp_w.size());
    end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_pc[i] !== exp_pc[i]) begin
        errors++; $display("FAIL busy_word%0d: got pc %0d %h, required pc %0d %h",
                           i, got_pc[i], got_w[i], exp_pc[i], exp_w[i]);
      end
    end
    drive_run(0, 0, 100, -1, 0, -1, 1'b0, 0, '0);
    checks++;
    if (got_w.size() != 1 || got_w[0] !== model_mem[0]) begin
      errors++; $display("FAIL busy_buffer: slot 0 reads %h (%0d issues), required %h",
                         (got_w.size() > 0) ? got_w[0] : 32'h0, got_w.size(), model_mem[0]);
    end
  endtask

  task automatic test_zero_words();
    int exp_n;
    int exp_lat;
`ifdef INSTR_FEEDER_SKIP_NOP_EN
    exp_n = 4; exp_lat = 2;
`else
    exp_n = 6; exp_lat = 1;
`endif
    load(1, 32'h0); load(5, 32'h0);
    drive_run(0, 5, 100, -1, 0, -1, 1'b0, 0, '0);
    checks++;
    if (got_w.size() != exp_n || issued_count !== 4'(exp_n)) begin
      errors++; $display("FAIL zero_count: got %0d issues count %0d, required %0d", got_w.size(), issued_count, exp_n);
    end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_pc[i] !== exp_pc[i]) begin
        errors++; $display("FAIL zero_word%0d: got pc %0d %h, required pc %0d %h",
                           i, got_pc[i], got_w[i], exp_pc[i], exp_w[i]);
      end
    end
    checks++;
    if (done_cyc - last_ack_cyc != exp_lat || done_pulses != 1) begin
      errors++; $display("FAIL zero_done: done %0d cycles after last ack (%0d pulses), required %0d (1)",
                         done_cyc - last_ack_cyc, done_pulses, exp_lat);
    end
  endtask

  task automatic test_same_cycle_load();
    logic [INSTR_W-1:0] w;
    w = $urandom() | 32'h1;
    drive_run(0, 2, 100, -1, 0, -1, 1'b1, 0, w);
    checks++;
    if (got_w.size() == 0 || got_w[0] !== w) begin
      errors++; $display("FAIL same_cycle_load: first word %h, required %h",
                         (got_w.size() > 0) ? got_w[0] : 32'h0, w);
    end
  endtask

  task automatic test_random_runs();
    int s, m;
    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < DEPTH; a++) load(a, ($urandom_range(3) == 0) ? 32'h0 : $urandom());
      s = int'($urandom_range(7));
      m = (r % 3 == 0) ? 7 : int'($urandom_range(7));
      drive_run(s, m, int'($urandom_range(100, 30)), -1, 0, -1, 1'b0, 0, '0);
      checks++;
      if (timeout || got_w.size() != exp_w.size() || issued_count !== 4'(exp_w.size())) begin
        errors++; $display("FAIL rand%0d_count: run %0d..%0d got %0d issues count %0d, required %0d",
                           r, s, m, got_w.size(), issued_count, exp_w.size());
      end
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
        checks++;
        if (got_w[i] !== exp_w[i] || got_pc[i] !== exp_pc[i]) begin
          errors++; $display("FAIL rand%0d_word%0d: got pc %0d %h, required pc %0d %h",
                             r, i, got_pc[i], got_w[i], exp_pc[i], exp_w[i]);
        end
      end
      checks++;
      if (done_pulses != 1 || idle_cyc != done_cyc + 1 || stab_err != 0) begin
        errors++; $display("FAIL rand%0d_ctrl: %0d done pulses idle %0d done %0d unstable %0d, required 1, done+1, 0",
                           r, done_pulses, idle_cyc, done_cyc, stab_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_stall();
    test_empty_range();
    test_midrun_reset();
    test_ignore_busy();
    test_zero_words();
    test_same_cycle_load();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
